// File: rtl/p4_router_egress_demux_if.sv
// p4_router_egress_demux_if: pipeline AXIS input, per-packet metadata,
// per-port AXIS egress and status for the egress demux.
interface p4_router_egress_demux_if #(
   parameter int NUM_PORTS = 11,
   parameter int EGR_SPEC_ID_WIDTH = 8,
   parameter int ING_PORT_ID_WIDTH = 8,
   parameter int DATA_BYTES = 8
);
   logic [8*DATA_BYTES-1:0] s_axis_tdata;
   logic [DATA_BYTES-1:0] s_axis_tkeep;
   logic s_axis_tlast;
   logic s_axis_tvalid;
   logic s_axis_tready;
   logic [EGR_SPEC_ID_WIDTH+ING_PORT_ID_WIDTH-1:0] user_metadata;
   logic user_metadata_valid;
   logic [NUM_PORTS*8*DATA_BYTES-1:0] m_axis_tdata;
   logic [NUM_PORTS*DATA_BYTES-1:0] m_axis_tkeep;
   logic [NUM_PORTS-1:0] m_axis_tlast;
   logic [NUM_PORTS-1:0] m_axis_tvalid;
   logic [NUM_PORTS-1:0] m_axis_tready;
   logic [ING_PORT_ID_WIDTH-1:0] m_ing_port_id;
   logic [31:0] drop_count;
   logic md_overflow;
   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, user_metadata,
             user_metadata_valid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
             m_ing_port_id, drop_count, md_overflow
   );
   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, user_metadata,
             user_metadata_valid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
             m_ing_port_id, drop_count, md_overflow
   );
endinterface

// File: rtl/p4_router_egress_demux.sv
// p4_router_egress_demux: steers each pipeline packet to the egress port named by
// its metadata egr_spec_id; out-of-range specs are swallowed and counted.
module p4_router_egress_demux #(
   parameter int NUM_PORTS = 11,
   parameter int EGR_SPEC_ID_WIDTH = 8,
   parameter int ING_PORT_ID_WIDTH = 8,
   parameter int DATA_BYTES = 8,
   parameter int MD_FIFO_DEPTH = 4
) (
   input logic clk,
   input logic areset,
   p4_router_egress_demux_if.slave bus
);
   localparam int AW = $clog2(MD_FIFO_DEPTH);
   localparam int EW = EGR_SPEC_ID_WIDTH;
   localparam int MW = EGR_SPEC_ID_WIDTH + ING_PORT_ID_WIDTH;
   localparam int DW = 8 * DATA_BYTES;
   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
   state_t state, state_nx;
   logic [MW-1:0] mem [MD_FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [MW-1:0] head;
   logic [EW-1:0] sel;
   logic [ING_PORT_ID_WIDTH-1:0] ing_id;
   logic [31:0] drop_cnt;
   logic ovf, empty, full, push, pop, hs_last;
   logic [NUM_PORTS-1:0] hit;
   // extra pointer MSB distinguishes full from empty
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head = mem[rd_ptr[AW-1:0]];
   assign pop = (state == IDLE) && !empty;
   assign push = bus.user_metadata_valid && (!full || pop);
   assign hit = (state == FWD) ? NUM_PORTS'(1) << sel : '0;
   assign bus.s_axis_tready = (state == DROP) || |(hit & bus.m_axis_tready);
   assign hs_last = bus.s_axis_tvalid && bus.s_axis_tready && bus.s_axis_tlast;
   assign bus.m_axis_tvalid = hit & {NUM_PORTS{bus.s_axis_tvalid}};
   assign bus.m_axis_tlast = hit & {NUM_PORTS{bus.s_axis_tlast}};
   assign bus.m_ing_port_id = ing_id;
   assign bus.drop_count = drop_cnt;
   assign bus.md_overflow = ovf;
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign bus.m_axis_tdata[g*DW +: DW] = hit[g] ? bus.s_axis_tdata : '0;
      assign bus.m_axis_tkeep[g*DATA_BYTES +: DATA_BYTES] = hit[g] ? bus.s_axis_tkeep : '0;
   end
   always_comb begin
      state_nx = state;
      if (state == IDLE)
         state_nx = empty ? IDLE : (int'(head[EW-1:0]) < NUM_PORTS ? FWD : DROP);
      else if (hs_last)
         state_nx = IDLE;
   end
   always_ff @(posedge clk or posedge areset)
      if (areset) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         sel <= '0;
         ing_id <= '0;
         drop_cnt <= '0;
         ovf <= 1'b0;
      end else begin
         state <= state_nx;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            sel <= head[EW-1:0];
            ing_id <= head[MW-1:EW];
         end
         if (bus.user_metadata_valid && full && !pop) ovf <= 1'b1;
         if (state == DROP && hs_last && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   // a full push with a simultaneous pop reuses the slot being read this cycle
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= bus.user_metadata;
endmodule

// File: tb/tb_p4_router_egress_demux.sv
// tb_p4_router_egress_demux: randomized packets checked against a routing model
// (port = egr if in range else drop) with per-feature scenario tasks.
module tb_p4_router_egress_demux;
   localparam int NP = 11;
   localparam int DB = 8;
   localparam int DW = 64;
   logic clk = 1'b0;
   logic areset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_drops = '0;

   p4_router_egress_demux_if #(.NUM_PORTS(NP), .EGR_SPEC_ID_WIDTH(8), .ING_PORT_ID_WIDTH(8),
      .DATA_BYTES(DB)) bus ();
   p4_router_egress_demux #(.NUM_PORTS(NP), .EGR_SPEC_ID_WIDTH(8), .ING_PORT_ID_WIDTH(8),
      .DATA_BYTES(DB), .MD_FIFO_DEPTH(4)) dut (.clk(clk), .areset(areset), .bus(bus));

   always #5 clk = ~clk;

   task automatic idle_inputs;
      bus.s_axis_tdata = '0;
      bus.s_axis_tkeep = '0;
      bus.s_axis_tlast = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.user_metadata = '0;
      bus.user_metadata_valid = 1'b0;
      bus.m_axis_tready = '1;
   endtask

   task automatic do_reset;
      idle_inputs();
      areset = 1'b1;
      repeat (2) @(posedge clk);
      #1 areset = 1'b0;
      exp_drops = '0;
   endtask

   // One packet: metadata strobed at cycle md_at, data offered from cycle lead.
   // Model: egr < NP goes to port egr, otherwise dropped. With metadata landing one
   // cycle after its strobe and one IDLE pop cycle, all-ready packets end at
   // max(lead, md_at+2) + len cycles.
   task automatic run_pkt(input logic [7:0] ing, input logic [7:0] egr, input int len,
                          input int md_at, input int lead, input int mode,
                          input bit send_md, input bit chk_lat);
      bit fwd = egr < NP;
      int e = fwd ? int'(egr) : 0;
      int beat = 0;
      int cyc = 0;
      logic [4:0] pat = 5'b11001;
      logic [NP-1:0] rdy;
      logic [NP-1:0] allowed = fwd ? NP'(1) << e : '0;
      logic [DW-1:0] data = {$urandom, $urandom};
      logic [DB-1:0] keep = DB'($urandom);
      bus.user_metadata = {ing, egr};
      while (beat < len && cyc < 200) begin
         rdy = (mode == 0) ? '1 : NP'($urandom);
         if (mode == 2) rdy[e] = pat[cyc % 5];
         bus.m_axis_tready = rdy;
         bus.user_metadata_valid = send_md && (cyc == md_at);
         bus.s_axis_tvalid = cyc >= lead;
         bus.s_axis_tdata = data;
         bus.s_axis_tkeep = keep;
         bus.s_axis_tlast = beat == len - 1;
         @(negedge clk);
         checks++;
         if ((bus.m_axis_tvalid & ~allowed) !== '0)
            begin errors++; $display("FAIL stray_valid: m_axis_tvalid=%b allowed=%b", bus.m_axis_tvalid, allowed); end
         checks++;
         if (fwd && bus.m_axis_tvalid[e] && bus.s_axis_tready !== rdy[e])
            begin errors++; $display("FAIL ready_mirror: s_axis_tready=%b ready[%0d]=%b", bus.s_axis_tready, e, rdy[e]); end
         if (bus.s_axis_tvalid && bus.s_axis_tready) begin
            checks++;
            if (fwd && (bus.m_axis_tvalid[e] !== 1'b1 || bus.m_axis_tdata[e*DW +: DW] !== data ||
                bus.m_axis_tkeep[e*DB +: DB] !== keep || bus.m_axis_tlast[e] !== (beat == len - 1) ||
                bus.m_ing_port_id !== ing))
               begin errors++; $display("FAIL beat: port %0d beat %0d got v=%b d=%h k=%h l=%b ing=%h want d=%h k=%h l=%b ing=%h", e, beat, bus.m_axis_tvalid[e], bus.m_axis_tdata[e*DW +: DW], bus.m_axis_tkeep[e*DB +: DB], bus.m_axis_tlast[e], bus.m_ing_port_id, data, keep, beat == len - 1, ing); end
            beat++;
            data = {$urandom, $urandom};
            keep = DB'($urandom);
         end
         @(posedge clk);
         #1 cyc++;
      end
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast = 1'b0;
      bus.user_metadata_valid = 1'b0;
      if (!fwd && exp_drops != 32'hFFFF_FFFF) exp_drops++;
      checks++;
      if (beat != len)
         begin errors++; $display("FAIL pkt_timeout: egr %0d delivered %0d beats, want %0d", egr, beat, len); end
      checks++;
      if (bus.drop_count !== exp_drops)
         begin errors++; $display("FAIL drop_count: got %h want %h", bus.drop_count, exp_drops); end
      if (chk_lat) begin
         checks++;
         if (cyc != ((lead > md_at + 2) ? lead : md_at + 2) + len)
            begin errors++; $display("FAIL latency: got %0d cycles want %0d", cyc, ((lead > md_at + 2) ? lead : md_at + 2) + len); end
      end
   endtask

   // No pending metadata: an offered beat must never be accepted.
   task automatic check_stall(input int n);
      bus.s_axis_tvalid = 1'b1;
      bus.m_axis_tready = '1;
      repeat (n) begin
         @(negedge clk);
         checks++;
         if (bus.s_axis_tready !== 1'b0 || bus.m_axis_tvalid !== '0)
            begin errors++; $display("FAIL stall: s_axis_tready=%b m_axis_tvalid=%b want 0", bus.s_axis_tready, bus.m_axis_tvalid); end
         @(posedge clk);
         #1;
      end
      bus.s_axis_tvalid = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      areset = 1'b1;
      #12;
      checks++;
      if (bus.s_axis_tready !== 1'b0 || bus.m_axis_tvalid !== '0 || bus.m_axis_tlast !== '0 ||
          bus.m_ing_port_id !== '0 || bus.drop_count !== '0 || bus.md_overflow !== 1'b0 ||
          bus.m_axis_tdata !== '0 || bus.m_axis_tkeep !== '0)
         begin errors++; $display("FAIL reset_state: rdy=%b v=%b l=%b ing=%h drops=%h ovf=%b", bus.s_axis_tready, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_ing_port_id, bus.drop_count, bus.md_overflow); end
      do_reset();
   endtask

   task automatic test_forward;
      run_pkt(8'h03, 8'h05, 3, 0, 1, 0, 1'b1, 1'b1);
      checks++;
      if (bus.m_ing_port_id !== 8'h03)
         begin errors++; $display("FAIL ing_hold: got %h want 03", bus.m_ing_port_id); end
   endtask

   task automatic test_drop;
      run_pkt(8'h11, 8'hFF, 4, 0, 1, 0, 1'b1, 1'b1);
      force dut.drop_cnt = 32'hFFFF_FFFE;
      @(posedge clk);
      #1 release dut.drop_cnt;
      exp_drops = 32'hFFFF_FFFE;
      run_pkt(8'h12, 8'h0B, 2, 0, 1, 0, 1'b1, 1'b0);
      run_pkt(8'h13, 8'h80, 1, 0, 1, 0, 1'b1, 1'b0);
      do_reset();
   endtask

   task automatic test_back_to_back;
      run_pkt(8'h40, 8'd0, 1, 0, 2, 0, 1'b1, 1'b1);
      run_pkt(8'h41, 8'd10, 1, 0, 2, 0, 1'b1, 1'b1);
      run_pkt(8'h42, 8'd2, 1, 0, 2, 0, 1'b1, 1'b1);
   endtask

   task automatic test_backpressure;
      run_pkt(8'h07, 8'd7, 5, 0, 1, 2, 1'b1, 1'b0);
   endtask

   // The first entry is popped straight into the FSM, so with depth 4 the sixth
   // consecutive strobe is the first to find the FIFO full.
   task automatic test_md_overflow;
      logic [7:0] ings [6];
      for (int i = 0; i < 6; i++) begin
         ings[i] = 8'($urandom);
         bus.user_metadata = {ings[i], 8'(i + 1)};
         bus.user_metadata_valid = 1'b1;
         @(posedge clk);
         #1 bus.user_metadata_valid = 1'b0;
         checks++;
         if (bus.md_overflow !== (i == 5))
            begin errors++; $display("FAIL md_overflow: strobe %0d got %b want %b", i + 1, bus.md_overflow, i == 5); end
      end
      for (int i = 0; i < 5; i++) run_pkt(ings[i], 8'(i + 1), 2, 0, 0, 1, 1'b0, 1'b0);
      check_stall(4);
      checks++;
      if (bus.md_overflow !== 1'b1)
         begin errors++; $display("FAIL md_overflow_sticky: got %b want 1", bus.md_overflow); end
   endtask

   task automatic test_reset_mid_packet;
      bus.user_metadata = {8'h21, 8'h04};
      bus.user_metadata_valid = 1'b1;
      @(posedge clk);
      #1 bus.user_metadata = {8'h22, 8'h06};
      @(posedge clk);
      #1 bus.user_metadata_valid = 1'b0;
      bus.m_axis_tready = '1;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata = 64'h1111;
      @(posedge clk);
      #1 bus.s_axis_tdata = 64'h2222;
      checks++;
      if (bus.m_axis_tvalid !== 11'b000_0001_0000)
         begin errors++; $display("FAIL mid_pkt_fwd: m_axis_tvalid=%b want port 4", bus.m_axis_tvalid); end
      #2 areset = 1'b1;
      #1;
      checks++;
      if (bus.m_axis_tvalid !== '0 || bus.s_axis_tready !== 1'b0)
         begin errors++; $display("FAIL async_reset: m_axis_tvalid=%b s_axis_tready=%b want 0", bus.m_axis_tvalid, bus.s_axis_tready); end
      @(posedge clk);
      #1 areset = 1'b0;
      exp_drops = '0;
      checks++;
      if (bus.md_overflow !== 1'b0 || bus.drop_count !== '0)
         begin errors++; $display("FAIL reset_clear: md_overflow=%b drop_count=%h", bus.md_overflow, bus.drop_count); end
      check_stall(4);
      run_pkt(8'h33, 8'd9, 3, 0, 1, 0, 1'b1, 1'b1);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] egr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(NP, 255)) : 8'($urandom_range(0, NP - 1));
         int mode = $urandom_range(0, 1);
         int md_at = $urandom_range(0, 2);
         int lead = $urandom_range(0, 3);
         run_pkt(8'($urandom), egr, $urandom_range(1, 4), md_at, lead, mode, 1'b1, mode == 0);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_drop();
      test_back_to_back();
      test_backpressure();
      test_md_overflow();
      test_reset_mid_packet();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
